// File: rtl/velocity_ramp.sv
// Slew-rate limiter for VX/VY/WZ sign-magnitude velocity commands, stepped on a prescaled tick.
// Optional emergency stop input is compiled in with VELOCITY_RAMP_ESTOP_EN.
module velocity_ramp #(
  parameter int                 N_WIDTH   = 17,
  parameter int                 PRESCALER = 500000,
  parameter logic [N_WIDTH-1:0] STEP_LIN  = 17'b0_00000010_00000000,
  parameter logic [N_WIDTH-1:0] STEP_ANG  = 17'b0_00000000_01000000
) (
  input  logic               VELOCITY_RAMP_CLOCK_50,
  input  logic               VELOCITY_RAMP_RESET_InHigh,
  input  logic               VELOCITY_RAMP_ENABLE_InHigh,
  input  logic               VELOCITY_RAMP_GOAL_FLAG_InLow,
  input  logic [N_WIDTH-1:0] VELOCITY_RAMP_VX_InBus,
  input  logic [N_WIDTH-1:0] VELOCITY_RAMP_VY_InBus,
  input  logic [N_WIDTH-1:0] VELOCITY_RAMP_WZ_InBus,
`ifdef VELOCITY_RAMP_ESTOP_EN
  input  logic               VELOCITY_RAMP_ESTOP_InHigh,
`endif
  output logic [N_WIDTH-1:0] VELOCITY_RAMP_VX_OutBus,
  output logic [N_WIDTH-1:0] VELOCITY_RAMP_VY_OutBus,
  output logic [N_WIDTH-1:0] VELOCITY_RAMP_WZ_OutBus,
  output logic               VELOCITY_RAMP_STOPPED_OutHigh,
  output logic               VELOCITY_RAMP_DONE_OutHigh
);

  localparam int                 MAG_W   = N_WIDTH - 1;
  localparam int                 CNT_W   = $clog2(PRESCALER);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(PRESCALER - 1);
  localparam logic [N_WIDTH-1:0] ZERO_W  = {N_WIDTH{1'b0}};
  localparam logic [MAG_W-1:0]   ZERO_M  = {MAG_W{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_q;
  logic               done_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [N_WIDTH-1:0] vx_q, vy_q, wz_q;
  logic [N_WIDTH-1:0] vx_d, vy_d, wz_d;
  logic               tick_s;
  logic               all_zero_s;
  logic               estop_s;

`ifdef VELOCITY_RAMP_ESTOP_EN
  assign estop_s = VELOCITY_RAMP_ESTOP_InHigh;
`else
  assign estop_s = 1'b0;
`endif

  // One axis step: reversals pass through zero, magnitude clamps at target, zero is always +0.
  function automatic logic [N_WIDTH-1:0] ramp_axis(input logic [N_WIDTH-1:0] cur,
                                                  input logic [N_WIDTH-1:0] tgt,
                                                  input logic [N_WIDTH-1:0] step);
    logic             cs, ts, ns;
    logic [MAG_W-1:0] cm, tm, sm, nm, dm;
    cs = cur[N_WIDTH-1];
    cm = cur[MAG_W-1:0];
    ts = tgt[N_WIDTH-1];
    tm = tgt[MAG_W-1:0];
    sm = step[MAG_W-1:0];
    if (tm == ZERO_M) ts = 1'b0;
    else              ts = ts;
    if (cm != ZERO_M && cs != ts) begin
      ns = cs;
      nm = (sm < cm) ? (cm - sm) : ZERO_M;
    end else if (tm > cm) begin
      ns = ts;
      dm = tm - cm;
      nm = cm + ((sm < dm) ? sm : dm);
    end else begin
      ns = ts;
      dm = cm - tm;
      nm = cm - ((sm < dm) ? sm : dm);
    end
    if (nm == ZERO_M) ns = 1'b0;
    else              ns = ns;
    return {ns, nm};
  endfunction

  assign tick_s     = (cnt_q == CNT_MAX);
  assign all_zero_s = (vx_q[MAG_W-1:0] == ZERO_M) && (vy_q[MAG_W-1:0] == ZERO_M) &&
                      (wz_q[MAG_W-1:0] == ZERO_M);

  // Free-running prescaler; only reset clears it.
  always_ff @(posedge VELOCITY_RAMP_CLOCK_50) begin
    if (VELOCITY_RAMP_RESET_InHigh) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (tick_s) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Control FSM; transitions are evaluated every cycle, DONE flag registered with the state.
  always_ff @(posedge VELOCITY_RAMP_CLOCK_50) begin
    if (VELOCITY_RAMP_RESET_InHigh) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else if (estop_s) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (VELOCITY_RAMP_ENABLE_InHigh && VELOCITY_RAMP_GOAL_FLAG_InLow) state_q <= RUN;
          else                                                             state_q <= IDLE;
        end
        RUN: begin
          if (!VELOCITY_RAMP_ENABLE_InHigh || !VELOCITY_RAMP_GOAL_FLAG_InLow) state_q <= STOP;
          else                                                               state_q <= RUN;
        end
        STOP: begin
          if (!all_zero_s) begin
            state_q <= STOP;
          end else if (!VELOCITY_RAMP_ENABLE_InHigh) begin
            state_q <= IDLE;
          end else if (!VELOCITY_RAMP_GOAL_FLAG_InLow) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        DONE: begin
          if (!VELOCITY_RAMP_ENABLE_InHigh) begin
            state_q <= IDLE;
          end else if (VELOCITY_RAMP_GOAL_FLAG_InLow) begin
            state_q <= RUN;
          end else begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Setpoint next-state: ramp toward inputs in RUN, toward zero in STOP, zero elsewhere.
  always_comb begin
    vx_d = vx_q;
    vy_d = vy_q;
    wz_d = wz_q;
    if (estop_s) begin
      vx_d = ZERO_W;
      vy_d = ZERO_W;
      wz_d = ZERO_W;
    end else begin
      case (state_q)
        RUN: begin
          if (tick_s) begin
            vx_d = ramp_axis(vx_q, VELOCITY_RAMP_VX_InBus, STEP_LIN);
            vy_d = ramp_axis(vy_q, VELOCITY_RAMP_VY_InBus, STEP_LIN);
            wz_d = ramp_axis(wz_q, VELOCITY_RAMP_WZ_InBus, STEP_ANG);
          end else begin
            vx_d = vx_q;
            vy_d = vy_q;
            wz_d = wz_q;
          end
        end
        STOP: begin
          if (tick_s) begin
            vx_d = ramp_axis(vx_q, ZERO_W, STEP_LIN);
            vy_d = ramp_axis(vy_q, ZERO_W, STEP_LIN);
            wz_d = ramp_axis(wz_q, ZERO_W, STEP_ANG);
          end else begin
            vx_d = vx_q;
            vy_d = vy_q;
            wz_d = wz_q;
          end
        end
        default: begin
          vx_d = ZERO_W;
          vy_d = ZERO_W;
          wz_d = ZERO_W;
        end
      endcase
    end
  end

  // Setpoint registers; reset is an abrupt stop.
  always_ff @(posedge VELOCITY_RAMP_CLOCK_50) begin
    if (VELOCITY_RAMP_RESET_InHigh) begin
      vx_q <= ZERO_W;
      vy_q <= ZERO_W;
      wz_q <= ZERO_W;
    end else begin
      vx_q <= vx_d;
      vy_q <= vy_d;
      wz_q <= wz_d;
    end
  end

  assign VELOCITY_RAMP_VX_OutBus       = vx_q;
  assign VELOCITY_RAMP_VY_OutBus       = vy_q;
  assign VELOCITY_RAMP_WZ_OutBus       = wz_q;
  assign VELOCITY_RAMP_STOPPED_OutHigh = all_zero_s;
  assign VELOCITY_RAMP_DONE_OutHigh    = done_q;

endmodule

// File: tb/tb_velocity_ramp.sv
// Directed bench for velocity_ramp with PRESCALER=4; expected values are hand-computed constants.
module tb_velocity_ramp;

  localparam int PRESC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        goal;
  logic [16:0] vx_i, vy_i, wz_i;
  logic [16:0] vx_o, vy_o, wz_o;
  logic        stopped_o, done_o;
`ifdef VELOCITY_RAMP_ESTOP_EN
  logic        estop;
`endif

  int   total = 0;
  int   bad   = 0;
  logic [1:0] tb_cnt;
  logic negz_seen = 1'b0;

  velocity_ramp #(.N_WIDTH(17), .PRESCALER(PRESC)) dut (
    .VELOCITY_RAMP_CLOCK_50        (clk),
    .VELOCITY_RAMP_RESET_InHigh    (rst),
    .VELOCITY_RAMP_ENABLE_InHigh   (en),
    .VELOCITY_RAMP_GOAL_FLAG_InLow (goal),
    .VELOCITY_RAMP_VX_InBus        (vx_i),
    .VELOCITY_RAMP_VY_InBus        (vy_i),
    .VELOCITY_RAMP_WZ_InBus        (wz_i),
`ifdef VELOCITY_RAMP_ESTOP_EN
    .VELOCITY_RAMP_ESTOP_InHigh    (estop),
`endif
    .VELOCITY_RAMP_VX_OutBus       (vx_o),
    .VELOCITY_RAMP_VY_OutBus       (vy_o),
    .VELOCITY_RAMP_WZ_OutBus       (wz_o),
    .VELOCITY_RAMP_STOPPED_OutHigh (stopped_o),
    .VELOCITY_RAMP_DONE_OutHigh    (done_o)
  );

  always #5 clk = ~clk;

  // Tick phase model: tick cycle is the one where tb_cnt == 3.
  always @(posedge clk) begin
    if (rst) tb_cnt <= 2'd0;
    else     tb_cnt <= tb_cnt + 2'd1;
  end

  // Negative zero must never appear on any output.
  always @(negedge clk) begin
    if (vx_o == 17'h10000 || vy_o == 17'h10000 || wz_o == 17'h10000) negz_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge just after the next tick update.
  task automatic tick_step;
    int waited = 0;
    while (tb_cnt != 2'd3 && waited < 8) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 8) begin
      total++;
      bad++;
      $error("FAIL tick_wait observed=timeout expected=tick");
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; goal = 1'b1;
    vx_i = 17'h00000; vy_i = 17'h00000; wz_i = 17'h00000;
`ifdef VELOCITY_RAMP_ESTOP_EN
    estop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_vx", vx_o, 17'h00000);
    chk("rst_stopped", {16'h0000, stopped_o}, 17'h00001);
    chk("rst_done", {16'h0000, done_o}, 17'h00000);

    // Ramp up VX to +50.
    rst = 1'b0; en = 1'b1;
    vx_i = 17'h03200;
    for (int k = 1; k <= 25; k++) begin
      tick_step();
      chk($sformatf("ramp_vx_%0d", k), vx_o, 17'(k * 512));
    end
    tick_step();
    chk("ramp_hold_vx", vx_o, 17'h03200);
    chk("ramp_vy", vy_o, 17'h00000);
    chk("ramp_wz", wz_o, 17'h00000);
    chk("ramp_stopped", {16'h0000, stopped_o}, 17'h00000);

    // Partial step: 50 -> 49 (1 below), then 49 -> 50 without overshoot.
    vx_i = 17'h03100;
    tick_step();
    chk("partial_down", vx_o, 17'h03100);
    vx_i = 17'h03200;
    tick_step();
    chk("partial_up", vx_o, 17'h03200);

    // Bring VX to +4, then reverse to -50.
    vx_i = 17'h00400;
    repeat (23) tick_step();
    chk("rev_start", vx_o, 17'h00400);
    vx_i = 17'h13200;
    tick_step(); chk("rev_p2", vx_o, 17'h00200);
    tick_step(); chk("rev_0",  vx_o, 17'h00000);
    tick_step(); chk("rev_m2", vx_o, 17'h10200);
    tick_step(); chk("rev_m4", vx_o, 17'h10400);

    // VX to +6, WZ to -0.5, then goal reached.
    vx_i = 17'h00600; wz_i = 17'h10080;
    repeat (5) tick_step();
    chk("goal_pre_vx", vx_o, 17'h00600);
    chk("goal_pre_wz", wz_o, 17'h10080);
    goal = 1'b0;
    tick_step(); chk("goal_vx4", vx_o, 17'h00400); chk("goal_wzq", wz_o, 17'h10040);
    tick_step(); chk("goal_vx2", vx_o, 17'h00200); chk("goal_wz0", wz_o, 17'h00000);
    tick_step(); chk("goal_vx0", vx_o, 17'h00000);
    chk("goal_done_early", {16'h0000, done_o}, 17'h00000);
    @(negedge clk);
    chk("goal_done", {16'h0000, done_o}, 17'h00001);
    chk("goal_stopped", {16'h0000, stopped_o}, 17'h00001);
    goal = 1'b1;
    @(negedge clk);
    chk("resume_done", {16'h0000, done_o}, 17'h00000);
    tick_step();
    chk("resume_vx", vx_o, 17'h00200);
    chk("resume_wz", wz_o, 17'h10040);

    // Reset mid-ramp: abrupt stop, then IDLE holds zero.
    rst = 1'b1; en = 1'b0;
    @(negedge clk);
    chk("midrst_vx", vx_o, 17'h00000);
    chk("midrst_wz", wz_o, 17'h00000);
    chk("midrst_stopped", {16'h0000, stopped_o}, 17'h00001);
    chk("midrst_done", {16'h0000, done_o}, 17'h00000);
    rst = 1'b0;
    tick_step();
    chk("idle_hold_vx", vx_o, 17'h00000);

    // Negative-zero target holds +0; VY steps toward -4.
    en = 1'b1; goal = 1'b1;
    vx_i = 17'h10000; vy_i = 17'h10400; wz_i = 17'h00000;
    tick_step();
    chk("negz_vx", vx_o, 17'h00000);
    chk("vy_m2", vy_o, 17'h10200);

    // ENABLE and GOAL fall together: STOP then IDLE, never DONE.
    en = 1'b0; goal = 1'b0;
    tick_step();
    chk("both_vy0", vy_o, 17'h00000);
    repeat (3) begin
      @(negedge clk);
      chk("both_no_done", {16'h0000, done_o}, 17'h00000);
    end
    en = 1'b1;
    tick_step();
    chk("idle_needs_goal", vy_o, 17'h00000);
    goal = 1'b1;
    tick_step();
    chk("idle_to_run", vy_o, 17'h10200);

`ifdef VELOCITY_RAMP_ESTOP_EN
    // Emergency stop at VX=+20.
    vx_i = 17'h01400; vy_i = 17'h00000;
    repeat (10) tick_step();
    chk("es_pre_vx", vx_o, 17'h01400);
    estop = 1'b1;
    @(negedge clk);
    chk("es_vx0", vx_o, 17'h00000);
    chk("es_stopped", {16'h0000, stopped_o}, 17'h00001);
    tick_step();
    chk("es_hold", vx_o, 17'h00000);
    estop = 1'b0;
    tick_step();
    chk("es_resume", vx_o, 17'h00200);
`endif

    chk("no_negzero", {16'h0000, negz_seen}, 17'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/velocity_ramp.md
# velocity_ramp

Slew-rate limiter placed directly downstream of the pose-error controller: it takes the step-valued VX/VY/WZ velocity commands and the active-low goal flag that the controller produces, and turns them into bounded-acceleration setpoints for the wheel inverse-kinematics stage. Updates happen on a prescaled control tick. Every command is ramped toward its target by a fixed step per tick, and a direction reversal always passes through zero. Once the goal is reached the block ramps to a controlled stop and reports completion.

## Interface
- N_WIDTH, 17, sign-magnitude fixed-point word: 1 sign bit, 8 integer bits, 8 fraction bits
- PRESCALER, 500000, clock cycles per control tick (10 ms at 50 MHz); minimum 2
- STEP_LIN, 17'b0_00000010_00000000, maximum VX/VY change per tick (2 cm/s)
- STEP_ANG, 17'b0_00000000_01000000, maximum WZ change per tick (0.25 rad/s)
- VELOCITY_RAMP_CLOCK_50  in  1  system clock, 50 MHz
- VELOCITY_RAMP_RESET_InHigh  in  1  synchronous, active-high reset
- VELOCITY_RAMP_ENABLE_InHigh  in  1  motion enable; level-sensitive
- VELOCITY_RAMP_GOAL_FLAG_InLow  in  1  0 = goal reached (controller output)
- VELOCITY_RAMP_VX_InBus / _VY_InBus / _WZ_InBus  in  N_WIDTH each  target commands
- VELOCITY_RAMP_VX_OutBus / _VY_OutBus / _WZ_OutBus  out  N_WIDTH each  ramped setpoints
- VELOCITY_RAMP_STOPPED_OutHigh  out  1  all three setpoints have zero magnitude
- VELOCITY_RAMP_DONE_OutHigh  out  1  goal reached and stop complete
- VELOCITY_RAMP_ESTOP_InHigh  in  1  emergency stop; present only with VELOCITY_RAMP_ESTOP_EN

## Operation
- Single clock with synchronous, active-high reset.
- The prescaler counter counts from 0 to PRESCALER-1 and wraps. tick = (count == PRESCALER-1). The counter runs in every state and clears only on reset.
- FSM states: IDLE, RUN, STOP, DONE.
  - IDLE: setpoints are held at 0. Goes to RUN when ENABLE=1 and GOAL_FLAG=1.
  - RUN: each tick, every axis steps toward its input target. Goes to STOP if ENABLE=0 or GOAL_FLAG=0.
  - STOP: targets are forced to 0 and each tick ramps toward 0. Once all magnitudes are 0, the exit is evaluated in priority order:
    1. ENABLE=0 → IDLE
    2. GOAL_FLAG=0 → DONE
    3. otherwise → RUN
  - DONE: setpoints stay at 0 and DONE=1. ENABLE=0 → IDLE. GOAL_FLAG=1 → RUN.
- Per-axis step rule, applied on a tick only. cur = current setpoint, tgt = target, s = STEP_LIN or STEP_ANG.
  - Magnitudes equal and signs equal, or both magnitudes 0: hold.
  - Signs differ and |cur| > 0: |cur| ← |cur| − min(s, |cur|), and the sign is kept.
  - Signs differ and |cur| = 0: the sign takes tgt's sign, then the magnitude rule below applies within the same tick.
  - Same sign: the magnitude moves toward |tgt| by min(s, ||tgt| − |cur||). It never overshoots.
- Negative zero is normalised: an input of 1_0…0 is treated as +0, and an output with magnitude 0 always has sign 0.
- Magnitude arithmetic is 16-bit unsigned. Because clamping is to the target, overflow is impossible.
- STOPPED is combinational from the output registers.

## Timing
- Reset values:
  - All setpoint outputs = 0.
  - STOPPED = 1, DONE = 0.
  - State = IDLE, prescaler count = 0.
- Setpoints and state are registered. An update computed on a tick cycle is visible on the following cycle.
- Latency from a target change to the first output change is at most PRESCALER+1 cycles.
- State transitions are evaluated every cycle, not only on ticks. Ramp steps occur only on ticks.
- Target inputs are sampled on the tick cycle. Changes between ticks have no effect.
- If ENABLE falls and GOAL_FLAG falls in the same cycle during RUN: go to STOP, then to IDLE (ENABLE has priority).
- DONE is asserted on the cycle after the last axis reaches 0 in STOP, while GOAL_FLAG=0 and ENABLE=1.
- Reset asserted mid-ramp: all outputs are 0 on the next cycle. This is an abrupt stop, with no ramping.

## Configuration
- VELOCITY_RAMP_ESTOP_EN defined:
  - The ESTOP_InHigh port exists.
  - ESTOP=1 zeroes all setpoints on the next cycle, ignoring the ramp, and forces IDLE.
  - The FSM stays in IDLE while ESTOP=1. It re-enters RUN only after ESTOP=0 with ENABLE=1 and GOAL_FLAG=1.
  - The prescaler is not affected.
- VELOCITY_RAMP_ESTOP_EN undefined: the port and its logic are absent. Stopping is ramped only, or abrupt through reset.

## Test plan
- Reset test: with ramps in progress, assert reset for 1 cycle → all setpoints 0, STOPPED=1, DONE=0, state IDLE.
- Ramp up (bench uses PRESCALER=4): ENABLE=1, GOAL_FLAG=1, VX target +50 (0_00110010_00000000).
  - VX rises by 2 each tick.
  - VX reaches +50 after 25 ticks (100 cycles) and then holds; VY and WZ stay 0.
- Partial step: VX at +49, target +50 → VX is exactly +50 after one tick, with no overshoot.
- Reversal: VX at +4, target −50 → successive ticks give +2, 0, −2, −4 …. Output 1_0…0 never appears.
- Goal stop: VX=+6, WZ=−0.5, GOAL_FLAG drops to 0.
  - VX steps 4, 2, 0.
  - WZ steps −0.25, 0.
  - DONE=1 the cycle after VX reaches 0.
  - Raising GOAL_FLAG to 1 returns the FSM to RUN.
- Emergency stop (with VELOCITY_RAMP_ESTOP_EN): assert ESTOP mid-ramp at VX=+20 → all setpoints 0 on the next cycle and the FSM in IDLE. After ESTOP is released, RUN resumes and VX ramps from 0.
